ps2_kbd_ctrl: RTL
=================

# ps2_kbd_ctrl

Host-side command sequencer and receive-stream arbiter for the PS/2 keyboard port. It sits between the byte-level PS/2 transceiver (receiver plus transmitter) and the ZX scan-code decoder. On start-up it resets the keyboard and checks the self-test result. After that it sends keyboard LED updates whenever the requested LED state changes. It keeps command responses out of the scan-code stream and forwards all other bytes to the decoder through a one-byte buffer.

## Interface
Parameters:
- ACK_TIMEOUT, 210000: clock cycles allowed from `tx_write` until the ACK/response byte arrives (15 ms at 14 MHz).
- BAT_TIMEOUT, 14000000: clock cycles allowed from the FF ACK until the BAT result byte arrives.
- MAX_RETRY, 3: number of resends allowed per byte after FE, `tx_error` or a timeout.

Ports (clock and reset first):
- clk  in  1  system clock (14 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- led_scroll, led_num, led_caps  in  1 each  requested LED levels.
- rx_scan_code  in  8  received byte from the transceiver.
- rx_data_ready  in  1  received byte is valid.
- rx_read  out  1  one-cycle pulse that consumes the received byte.
- tx_data  out  8  byte to transmit.
- tx_write  out  1  one-cycle pulse that starts a transmission.
- tx_busy  in  1  transmitter is busy.
- tx_error  in  1  one-cycle pulse: the device NACKed the frame or the frame timed out.
- kb_data  out  8  forwarded byte to the decoder.
- kb_ready  out  1  `kb_data` is valid; held until `kb_read`.
- kb_read  in  1  decoder consumes `kb_data`.
- kb_ok  out  1  keyboard passed BAT.
- cmd_busy  out  1  a command sequence is in progress.
- err  out  1  sticky command failure.

## Operation
- Reset values: `rx_read`=0, `tx_write`=0, `tx_data`=00, `kb_data`=00, `kb_ready`=0, `kb_ok`=0, `err`=0, `cmd_busy`=1, state=RST_SEND, retry=0, timer=0, `led_sent`=3'b000, `led_pending`=1.
- LED byte order: `led_req` = {`led_caps`, `led_num`, `led_scroll`}, which maps to bits 2..0 of the ED argument.
- States:
  - RST_SEND: wait until `tx_busy`=0, then pulse `tx_write` with FF. Go to RST_ACK.
  - RST_ACK: on FA go to RST_BAT. On FE or `tx_error`, resend.
  - RST_BAT: on AA set `kb_ok`=1 and go to IDLE. On FC set `err`=1, keep `kb_ok`=0, go to IDLE.
  - IDLE: `cmd_busy`=0. If `led_pending`, or `led_req` differs from `led_sent`, and `tx_busy`=0, go to LED_CMD.
  - LED_CMD: pulse `tx_write` with ED. Go to LED_ACK.
  - LED_ACK: on FA go to LED_VAL.
  - LED_VAL: latch `led_req` as `led_arg` and pulse `tx_write` with {5'b0, `led_arg`}. Go to LED_VACK.
  - LED_VACK: on FA set `led_sent`=`led_arg`, clear `led_pending`, go to IDLE.
- Resend rule, applied in every *_ACK state: on FE, `tx_error` or ACK_TIMEOUT expiry:
  - If retry < MAX_RETRY: increment retry and return to the matching send state. LED_VACK resends only the value byte; it does not resend ED.
  - Otherwise: set `err`=1, set `led_pending`=0, set `led_sent`=`led_req`, go to IDLE.
  - Retry clears on every accepted FA.
- RST_BAT timeout: set `err`=1, `kb_ok`=0, go to IDLE.
- Received bytes, in any state: when `rx_data_ready`=1, pulse `rx_read` for one cycle.
  - In a waiting state, FA, FE, AA and FC are consumed by the FSM and never forwarded.
  - Every other byte is loaded into `kb_data` and sets `kb_ready` if `kb_ready`=0. If `kb_ready`=1 the byte is dropped.
- `kb_read` while `kb_ready`=1 clears `kb_ready` on the next edge. A new byte and `kb_read` in the same cycle: the new byte is loaded and `kb_ready` stays 1.
- `err` is cleared only by reset.
- LED changes during a sequence are not lost: they are detected in IDLE after the sequence completes.
- `cmd_busy`=1 in every state except IDLE.

## Timing
- `tx_write` is issued in the first cycle the send state sees `tx_busy`=0. It is never issued while `tx_busy`=1.
- The timer loads in the `tx_write` cycle and counts every cycle. It expires when the count reaches ACK_TIMEOUT (or BAT_TIMEOUT in RST_BAT). A byte arriving in the expiry cycle wins over the timeout.
- `rx_read` is a single cycle. `rx_data_ready` is ignored in the cycle after `rx_read`.
- Latency, `rx_data_ready` to `kb_ready`: 1 cycle.
- Latency, LED change in IDLE to `tx_write`(ED): 2 cycles.
- `reset_n` low in mid-sequence aborts asynchronously to the reset values, and the reset sequence reruns after release.

## Test plan
- Reset release; device returns FA then AA -> FF sent; `kb_ok`=1; then ED and 00 sent; `cmd_busy`=0; `err`=0.
- In IDLE, set `led_num`=1, device returns FA, FA -> `tx_data` ED then 02; `led_sent`=010; no bytes forwarded to `kb_data`.
- After ED, device returns FE twice then FA -> ED transmitted 3 times total, then value byte; `err`=0.
- No response to ED (ACK_TIMEOUT=100) -> 4 ED attempts, then `err`=1, return to IDLE, `cmd_busy`=0.
- Scan code 1C during LED_ACK while `kb_ready`=0 -> `kb_data`=1C, `kb_ready`=1; a second byte 1B before `kb_read` -> dropped; FA still consumed.
- Device returns FC after the FF ACK -> `err`=1, `kb_ok`=0; assert `reset_n` low in LED_VACK -> all outputs return to their reset values immediately.

Source files
------------

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: PS/2 host sequencer (reset + BAT check, LED updates) and receive-stream arbiter.
// Latency: rx_data_ready -> kb_ready 1 cycle; LED change seen in IDLE -> tx_write(ED) 2 cycles.
// Backpressure: tx waits for tx_busy=0; one-byte kb buffer held until kb_read, bytes arriving while full are dropped.
//
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   led_scroll/led_num/led_caps    requested LED levels (ED argument bits 0/1/2)
//   rx_scan_code, rx_data_ready    received byte from transceiver; rx_read consumes it
//   tx_data, tx_write              byte to send and its start pulse; tx_busy/tx_error from transmitter
//   kb_data, kb_ready, kb_read     forwarded byte buffer toward the scan-code decoder
//   kb_ok, cmd_busy, err           BAT passed, sequence in progress, sticky command failure
module ps2_kbd_ctrl #(
  parameter int ACK_TIMEOUT = 210000,
  parameter int BAT_TIMEOUT = 14000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       led_scroll,
  input  logic       led_num,
  input  logic       led_caps,
  input  logic [7:0] rx_scan_code,
  input  logic       rx_data_ready,
  output logic       rx_read,
  output logic [7:0] tx_data,
  output logic       tx_write,
  input  logic       tx_busy,
  input  logic       tx_error,
  output logic [7:0] kb_data,
  output logic       kb_ready,
  input  logic       kb_read,
  output logic       kb_ok,
  output logic       cmd_busy,
  output logic       err
);
  localparam int TMAX = (BAT_TIMEOUT > ACK_TIMEOUT) ? BAT_TIMEOUT : ACK_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = $clog2(MAX_RETRY + 2);
  localparam logic [TW-1:0] ACK_LIM   = TW'(ACK_TIMEOUT);
  localparam logic [TW-1:0] BAT_LIM   = TW'(BAT_TIMEOUT);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_LEDS     = 8'hED;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

  typedef enum logic [2:0] {
    RST_SEND, RST_ACK, RST_BAT, IDLE, LED_CMD, LED_ACK, LED_VAL, LED_VACK
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [RW-1:0] retry, retry_n;
  logic [2:0]    led_req, led_sent, led_sent_n, led_arg, led_arg_n;
  logic          led_pending, led_pending_n;
  logic          tx_write_n, kb_ok_n, err_n;
  logic [7:0]    tx_data_n;
  logic          waiting, is_rsp, rx_take, rsp_take, fwd_take;
  logic          got_fa, got_fe, got_aa, got_fc, expired, nack;

  assign led_req  = {led_caps, led_num, led_scroll};
  assign cmd_busy = (state != IDLE);

  // rx_data_ready is ignored in the cycle after rx_read, as the transceiver may not have dropped it yet.
  assign rx_take = rx_data_ready & ~rx_read;
  assign waiting = (state == RST_ACK) | (state == RST_BAT) | (state == LED_ACK) | (state == LED_VACK);
  assign is_rsp  = (rx_scan_code == RSP_ACK) | (rx_scan_code == RSP_RESEND) |
                   (rx_scan_code == RSP_BAT_OK) | (rx_scan_code == RSP_BAT_FAIL);
  // Response codes are swallowed only while a response is expected; otherwise they are keyboard data.
  assign rsp_take = rx_take & waiting & is_rsp;
  assign fwd_take = rx_take & ~(waiting & is_rsp);
  assign got_fa   = rsp_take & (rx_scan_code == RSP_ACK);
  assign got_fe   = rsp_take & (rx_scan_code == RSP_RESEND);
  assign got_aa   = rsp_take & (rx_scan_code == RSP_BAT_OK);
  assign got_fc   = rsp_take & (rx_scan_code == RSP_BAT_FAIL);
  assign expired  = (state == RST_BAT) ? (timer == BAT_LIM) : (timer == ACK_LIM);
  assign nack     = got_fe | tx_error | expired;

  always_comb begin
    state_n       = state;
    timer_n       = '0;
    retry_n       = retry;
    led_sent_n    = led_sent;
    led_arg_n     = led_arg;
    led_pending_n = led_pending;
    tx_write_n    = 1'b0;
    tx_data_n     = tx_data;
    kb_ok_n       = kb_ok;
    err_n         = err;
    case (state)
      RST_SEND: if (!tx_busy) begin
        tx_write_n = 1'b1;
        tx_data_n  = CMD_RESET;
        state_n    = RST_ACK;
      end
      LED_CMD: if (!tx_busy) begin
        tx_write_n = 1'b1;
        tx_data_n  = CMD_LEDS;
        state_n    = LED_ACK;
      end
      LED_VAL: if (!tx_busy) begin
        // Sample the request now so a resend carries the latest LED levels.
        led_arg_n  = led_req;
        tx_write_n = 1'b1;
        tx_data_n  = {5'b0, led_req};
        state_n    = LED_VACK;
      end
      RST_ACK, LED_ACK, LED_VACK: begin
        // An ACK arriving in the expiry cycle takes priority over the timeout.
        if (got_fa) begin
          retry_n = '0;
          if (state == RST_ACK) state_n = RST_BAT;
          else if (state == LED_ACK) state_n = LED_VAL;
          else begin
            led_sent_n    = led_arg;
            led_pending_n = 1'b0;
            state_n       = IDLE;
          end
        end else if (nack) begin
          if (retry < RETRY_LIM) begin
            retry_n = retry + 1'b1;
            state_n = (state == RST_ACK) ? RST_SEND : (state == LED_ACK) ? LED_CMD : LED_VAL;
          end else begin
            // Give up; adopting the request as sent stops IDLE from retrying forever.
            retry_n       = '0;
            err_n         = 1'b1;
            led_pending_n = 1'b0;
            led_sent_n    = led_req;
            state_n       = IDLE;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      RST_BAT: begin
        if (got_aa) begin
          kb_ok_n = 1'b1;
          state_n = IDLE;
        end else if (got_fc || expired) begin
          err_n   = 1'b1;
          kb_ok_n = 1'b0;
          state_n = IDLE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      IDLE: if ((led_pending || (led_req != led_sent)) && !tx_busy) state_n = LED_CMD;
      default: state_n = RST_SEND;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RST_SEND;
      timer       <= '0;
      retry       <= '0;
      led_sent    <= 3'b000;
      led_arg     <= 3'b000;
      led_pending <= 1'b1;
      tx_write    <= 1'b0;
      tx_data     <= 8'h00;
      kb_ok       <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      retry       <= retry_n;
      led_sent    <= led_sent_n;
      led_arg     <= led_arg_n;
      led_pending <= led_pending_n;
      tx_write    <= tx_write_n;
      tx_data     <= tx_data_n;
      kb_ok       <= kb_ok_n;
      err         <= err_n;
    end
  end

  // One-byte forward buffer: a simultaneous kb_read frees the slot for the incoming byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_read  <= 1'b0;
      kb_data  <= 8'h00;
      kb_ready <= 1'b0;
    end else begin
      rx_read <= rx_take;
      if (fwd_take && (!kb_ready || kb_read)) begin
        kb_data  <= rx_scan_code;
        kb_ready <= 1'b1;
      end else if (kb_read) begin
        kb_ready <= 1'b0;
      end
    end
  end
endmodule
